// File: rtl/ucode_sequencer.sv
// ucode_sequencer: T-state counter, microcode ROM address former and microword decoder with ALU flag register and jump resolve.
// Latency: strobes and jmp are combinational from udata (zero cycles); tstate and flags update on the next rising edge.
// Backpressure: with UCODE_STALL_EN defined, stall freezes tstate/flags and masks input strobes, RT, PP and jmp; otherwise stall is ignored.
module ucode_sequencer #(
    parameter int TBITS  = 3,
    parameter int OPBITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPBITS-1:0]       opcode,
    input  logic [15:0]             udata,
    input  logic                    alu_z,
    input  logic                    alu_lt,
    input  logic                    alu_c,
    input  logic                    stall,
    output logic [OPBITS+TBITS-1:0] uaddr,
    output logic [TBITS-1:0]        tstate,
    output logic                    EO_bar,
    output logic                    PO_bar,
    output logic                    IOH_bar,
    output logic                    IOL_bar,
    output logic                    RO,
    output logic                    DO,
    output logic                    MI_bar,
    output logic                    II_bar,
    output logic                    XI_bar,
    output logic                    YI_bar,
    output logic                    RI,
    output logic                    DI,
    output logic                    RT,
    output logic                    PP,
    output logic [5:0]              ALU_flags,
    output logic                    jmp
);

    localparam logic [TBITS-1:0] T_LAST = '1;

    logic [TBITS-1:0] tstate_q, tstate_d;
    logic             z_q, lt_q, c_q;
    logic             z_d, lt_d, c_d;
    logic             hold;
    logic             unused_rsvd;

    logic             eo_sel, po_sel, ioh_sel, iol_sel, ro_sel, do_sel;
    logic             mi_stb, ii_stb, xi_stb, yi_stb, ri_stb, di_stb;
    logic             rt_dec, pp_dec, jmp_dec;
    logic [5:0]       alu_flags_dec;

`ifdef UCODE_STALL_EN
    assign hold        = stall;
    assign unused_rsvd = ^udata[1:0];
`else
    assign hold        = 1'b0;
    assign unused_rsvd = ^{stall, udata[1:0]};
`endif

    // Microword decode; reset silences every strobe regardless of udata.
    always_comb begin
        eo_sel        = 1'b0;
        po_sel        = 1'b0;
        ioh_sel       = 1'b0;
        iol_sel       = 1'b0;
        ro_sel        = 1'b0;
        do_sel        = 1'b0;
        mi_stb        = 1'b0;
        ii_stb        = 1'b0;
        xi_stb        = 1'b0;
        yi_stb        = 1'b0;
        ri_stb        = 1'b0;
        di_stb        = 1'b0;
        rt_dec        = 1'b0;
        pp_dec        = 1'b0;
        jmp_dec       = 1'b0;
        alu_flags_dec = 6'h00;
        if (!reset) begin
            if (!udata[15]) begin
                eo_sel        = 1'b1;
                alu_flags_dec = udata[14:9];
            end else begin
                case (udata[14:12])
                    3'b000:  po_sel  = 1'b1;
                    3'b001:  ioh_sel = 1'b1;
                    3'b010:  iol_sel = 1'b1;
                    3'b011:  ro_sel  = 1'b1;
                    3'b110:  do_sel  = 1'b1;
                    default: ;
                endcase
            end
            if (!hold) begin
                case (udata[8:6])
                    3'b001:  mi_stb = 1'b1;
                    3'b010:  ii_stb = 1'b1;
                    3'b011:  ri_stb = 1'b1;
                    3'b100:  xi_stb = 1'b1;
                    3'b101:  yi_stb = 1'b1;
                    3'b110:  di_stb = 1'b1;
                    default: ;
                endcase
                // RT/PP share bit positions with ALU flags, so they only count when EO is off.
                rt_dec  = udata[15] & udata[11];
                pp_dec  = udata[15] & udata[10];
                jmp_dec = (udata[5] & c_q) | (udata[4] & z_q) | (udata[2] & lt_q)
                        | (udata[3] & ~z_q & ~lt_q);
            end
        end
    end

    always_comb begin
        tstate_d = tstate_q;
        z_d      = z_q;
        lt_d     = lt_q;
        c_d      = c_q;
        if (reset) begin
            tstate_d = '0;
            z_d      = 1'b0;
            lt_d     = 1'b0;
            c_d      = 1'b0;
        end else if (!hold) begin
            if (rt_dec || tstate_q == T_LAST) begin
                tstate_d = '0;
            end else begin
                tstate_d = tstate_q + TBITS'(1);
            end
            if (eo_sel) begin
                z_d  = alu_z;
                lt_d = alu_lt;
                c_d  = alu_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        tstate_q <= tstate_d;
        z_q      <= z_d;
        lt_q     <= lt_d;
        c_q      <= c_d;
    end

    assign uaddr     = {opcode, tstate_q};
    assign tstate    = tstate_q;
    assign EO_bar    = ~eo_sel;
    assign PO_bar    = ~po_sel;
    assign IOH_bar   = ~ioh_sel;
    assign IOL_bar   = ~iol_sel;
    assign RO        = ro_sel;
    assign DO        = do_sel;
    assign MI_bar    = ~mi_stb;
    assign II_bar    = ~ii_stb;
    assign XI_bar    = ~xi_stb;
    assign YI_bar    = ~yi_stb;
    assign RI        = ri_stb;
    assign DI        = di_stb;
    assign RT        = rt_dec;
    assign PP        = pp_dec;
    assign ALU_flags = alu_flags_dec;
    assign jmp       = jmp_dec;

endmodule
